// File: rtl/fsqrt_issue_ctrl.sv
// Issue/response wrapper around a pipelined fsqrt unit: tags operands, patches IEEE
// special cases and buffers results in a credit-protected FIFO.
module fsqrt_issue_ctrl #(
  parameter int TAG_W     = 4,
  parameter int DEPTH     = 8,
  parameter int FSQRT_LAT = 3
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_x,
  input  logic [TAG_W-1:0] req_tag,
  output logic             sq_valid,
  output logic [31:0]      sq_x,
  input  logic [31:0]      sq_y,
  input  logic             sq_out_valid,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_y,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             err_sync
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = $clog2(FSQRT_LAT + 1);

  typedef enum logic {DRAIN, RUN} state_t;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic             ovr_en;
    logic [31:0]      ovr_val;
  } tp_t;

  state_t             state_q;
  logic [DW-1:0]      drain_q;
  tp_t                iss_q;
  tp_t                pipe_q [FSQRT_LAT];
  logic [31:0]        sq_x_q;
  logic               err_q;
  logic [CW-1:0]      count_q, count_d;
  logic [CW-1:0]      inflight_q, inflight_d;
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [31+TAG_W:0]  mem_q [DEPTH];

  tp_t                head;
  logic               accept, wr, pop;
  logic               ovr_en;
  logic [31:0]        ovr_val, wr_y;

  assign head      = pipe_q[FSQRT_LAT-1];
  assign wr        = head.vld;
  assign wr_y      = head.ovr_en ? head.ovr_val : sq_y;
  assign req_ready = (state_q == RUN) &&
                     (({1'b0, count_q} + {1'b0, inflight_q}) < (CW+1)'(DEPTH));
  assign accept    = req_valid & req_ready;
  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_y     = mem_q[rd_ptr_q][TAG_W +: 32];
  assign rsp_tag   = mem_q[rd_ptr_q][TAG_W-1:0];
  assign sq_valid  = iss_q.vld;
  assign sq_x      = sq_x_q;
  assign err_sync  = err_q;

  // Special operands still go through fsqrt so ordering is kept; only the result is replaced.
  always_comb begin
    ovr_en  = 1'b1;
    ovr_val = 32'h0;
    if (req_x[30:23] == 8'h00)
      ovr_val = {req_x[31], 31'b0};
    else if (req_x[30:23] == 8'hFF && req_x[22:0] != 23'h0)
      ovr_val = 32'h7FC00000;
    else if (req_x[30:23] == 8'hFF && !req_x[31])
      ovr_val = 32'h7F800000;
    else if (req_x[31])
      ovr_val = 32'h7FFFFFFF;
    else
      ovr_en = 1'b0;
  end

  always_comb begin
    inflight_d = inflight_q;
    if (accept && !wr)      inflight_d = inflight_q + CW'(1);
    else if (!accept && wr) inflight_d = inflight_q - CW'(1);
    count_d = count_q;
    if (wr && !pop)      count_d = count_q + CW'(1);
    else if (!wr && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= DRAIN;
      drain_q    <= DW'(FSQRT_LAT);
      iss_q      <= '0;
      sq_x_q     <= '0;
      err_q      <= 1'b0;
      count_q    <= '0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < FSQRT_LAT; i++) pipe_q[i] <= '0;
    end else begin
      case (state_q)
        DRAIN: begin
          drain_q <= drain_q - DW'(1);
          if (drain_q <= DW'(1)) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase

      iss_q <= accept ? '{vld: 1'b1, tag: req_tag, ovr_en: ovr_en, ovr_val: ovr_val} : '0;
      if (accept) sq_x_q <= req_x;
      pipe_q[0] <= iss_q;
      for (int i = 1; i < FSQRT_LAT; i++) pipe_q[i] <= pipe_q[i-1];

      // fsqrt output valid must line up exactly with the tag pipeline head.
      if (state_q == RUN && head.vld != sq_out_valid) err_q <= 1'b1;

      inflight_q <= inflight_d;
      count_q    <= count_d;
      if (wr)  wr_ptr_q <= (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
      if (pop) rd_ptr_q <= (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr) mem_q[wr_ptr_q] <= {wr_y, head.tag};
  end

endmodule

// File: tb/tb_fsqrt_issue_ctrl.sv
// Scoreboard bench for fsqrt_issue_ctrl with a behavioural 3-cycle fsqrt model.
module tb_fsqrt_issue_ctrl;

  localparam int TAG_W = 4;
  localparam int DEPTH = 8;
  localparam int LAT   = 3;

  logic             sys_clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [31:0]      req_x = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             sq_valid;
  logic [31:0]      sq_x;
  logic [31:0]      sq_y;
  logic             sq_out_valid;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_y;
  logic [TAG_W-1:0] rsp_tag;
  logic             err_sync;

  logic             drop = 1'b0;
  logic             inject = 1'b0;
  logic [LAT-1:0]   mv;
  logic [31:0]      my [LAT];

  typedef struct packed {
    logic [31:0]      y;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  fsqrt_issue_ctrl #(.TAG_W(TAG_W), .DEPTH(DEPTH), .FSQRT_LAT(LAT)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_tag(req_tag),
    .sq_valid(sq_valid), .sq_x(sq_x), .sq_y(sq_y), .sq_out_valid(sq_out_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_tag(rsp_tag),
    .err_sync(err_sync)
  );

  always #5 sys_clk = ~sys_clk;

  // Stand-in fsqrt: exact for even-exponent powers of two, deterministic elsewhere.
  function automatic logic [31:0] fsqrt_model(input logic [31:0] x);
    return (x >> 1) + 32'h1FC00000;
  endfunction

  function automatic logic [31:0] expected_y(input logic [31:0] x);
    if (x[30:23] == 8'h00)                          return {x[31], 31'b0};
    if (x[30:23] == 8'hFF && x[22:0] != 23'h0)     return 32'h7FC00000;
    if (x[30:23] == 8'hFF && !x[31])               return 32'h7F800000;
    if (x[31])                                     return 32'h7FFFFFFF;
    return fsqrt_model(x);
  endfunction

  always @(posedge sys_clk) begin
    if (rst) mv <= '0;
    else begin
      mv    <= {mv[LAT-2:0], sq_valid};
      my[0] <= fsqrt_model(sq_x);
      for (int i = 1; i < LAT; i++) my[i] <= my[i-1];
    end
  end
  assign sq_out_valid = (mv[LAT-1] & ~drop) | inject;
  assign sq_y         = my[LAT-1];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog");
  end

  // One clock cycle starting at a negedge; records accepts into the scoreboard.
  task automatic drive_cycle(input logic v, input logic [31:0] x, input logic [TAG_W-1:0] tg,
                             input logic rr, output logic acc, output logic pop,
                             output logic rv, output logic [31:0] y,
                             output logic [TAG_W-1:0] t, output logic rdy);
    req_valid = v; req_x = x; req_tag = tg; rsp_ready = rr;
    #1;
    rdy = req_ready;
    acc = v & req_ready;
    rv  = rsp_valid;
    pop = rsp_valid & rr;
    y   = rsp_y;
    t   = rsp_tag;
    if (acc) sb.push_back('{y: expected_y(x), tag: tg});
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    logic acc, pop, rv, rdy; logic [31:0] y; logic [TAG_W-1:0] t;
    int pops = 0;
    rst = 1'b1; rsp_ready = 1'b1; req_valid = 1'b0;
    repeat (3) @(negedge sys_clk);
    rst = 1'b0; sb.delete();
    #1;
    tests++;
    if (sq_valid !== 1'b0 || sq_x !== 32'h0 || rsp_valid !== 1'b0 || err_sync !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_values: sq_valid=%b sq_x=%h rsp_valid=%b err_sync=%b, need 0/0/0/0",
               sq_valid, sq_x, rsp_valid, err_sync);
    end
    for (int c = 0; c < 4; c++) begin
      inject = (c < 3);
      drive_cycle(c < 3, 32'h40800000, '0, 1'b1, acc, pop, rv, y, t, rdy);
      tests++;
      if (rdy !== (c == 3)) begin
        fails++;
        $display("[TB] FAIL drain_ready cycle %0d: got %b need %b", c, rdy, c == 3);
      end
    end
    inject = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive_cycle(1'b0, '0, '0, 1'b1, acc, pop, rv, y, t, rdy);
      if (pop) pops++;
    end
    tests++;
    if (pops != 0 || err_sync !== 1'b0) begin
      fails++;
      $display("[TB] FAIL drain_inject: responses=%0d err_sync=%b, need 0 and 0", pops, err_sync);
    end
  endtask

  task automatic test_single();
    logic acc, pop, rv, rdy; logic [31:0] y; logic [TAG_W-1:0] t; exp_t e;
    int lat = -1;
    drive_cycle(1'b1, 32'h40800000, 4'd5, 1'b1, acc, pop, rv, y, t, rdy);
    tests++;
    if (acc !== 1'b1 || sq_valid !== 1'b1 || sq_x !== 32'h40800000) begin
      fails++;
      $display("[TB] FAIL single_issue: acc=%b sq_valid=%b sq_x=%h, need 1/1/40800000", acc, sq_valid, sq_x);
    end
    for (int c = 1; c < 12; c++) begin
      drive_cycle(1'b0, '0, '0, 1'b1, acc, pop, rv, y, t, rdy);
      if (pop) begin
        if (lat < 0) lat = c;
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("[TB] FAIL single_extra: unexpected y=%h tag=%0d", y, t);
        end else begin
          e = sb.pop_front();
          if (y !== 32'h40000000 || y !== e.y || t !== 4'd5) begin
            fails++; $display("[TB] FAIL single_data: got y=%h tag=%0d need y=40000000 tag=5", y, t);
          end
        end
      end
    end
    tests++;
    if (lat != 5) begin
      fails++; $display("[TB] FAIL single_latency: got %0d cycles need 5", lat);
    end
  endtask

  task automatic test_specials();
    logic acc, pop, rv, rdy; logic [31:0] y; logic [TAG_W-1:0] t; exp_t e;
    logic [31:0] xs [7] = '{32'h00000000, 32'h80000000, 32'h00000001, 32'h7F800000,
                            32'h7F800001, 32'hFF800000, 32'hC0800000};
    logic [31:0] ys [7] = '{32'h00000000, 32'h80000000, 32'h00000000, 32'h7F800000,
                            32'h7FC00000, 32'h7FFFFFFF, 32'h7FFFFFFF};
    int n = 0;
    for (int c = 0; c < 17; c++) begin
      if (c < 7) drive_cycle(1'b1, xs[c], TAG_W'(c), 1'b1, acc, pop, rv, y, t, rdy);
      else       drive_cycle(1'b0, '0, '0, 1'b1, acc, pop, rv, y, t, rdy);
      if (pop) begin
        tests++;
        if (sb.size() == 0 || n >= 7) begin
          fails++; $display("[TB] FAIL special_extra: unexpected y=%h tag=%0d", y, t);
        end else begin
          e = sb.pop_front();
          if (y !== ys[n] || y !== e.y || t !== TAG_W'(n)) begin
            fails++;
            $display("[TB] FAIL special_%0d: got y=%h tag=%0d need y=%h tag=%0d", n, y, t, ys[n], n);
          end
        end
        n++;
      end
    end
    tests++;
    if (n != 7) begin
      fails++; $display("[TB] FAIL special_count: got %0d responses need 7", n);
    end
  endtask

  task automatic test_backpressure();
    logic acc, pop, rv, rdy; logic [31:0] y; logic [TAG_W-1:0] t; exp_t e;
    logic [31:0] held_y = '0; logic seen = 1'b0; logic stable = 1'b1;
    int accepts = 0, pops = 0, first_pop = -1;
    for (int c = 0; c < 20; c++) begin
      drive_cycle(1'b1, $urandom(), TAG_W'(c), 1'b0, acc, pop, rv, y, t, rdy);
      if (acc) accepts++;
      if (rv && !seen) begin seen = 1'b1; held_y = y; end
      else if (rv && y !== held_y) stable = 1'b0;
    end
    tests++;
    if (accepts != DEPTH || rdy !== 1'b0) begin
      fails++; $display("[TB] FAIL bp_credits: accepts=%0d ready=%b need %0d and 0", accepts, rdy, DEPTH);
    end
    tests++;
    if (!seen || !stable) begin
      fails++; $display("[TB] FAIL bp_stable: seen=%b stable=%b need 1 and 1", seen, stable);
    end
    for (int c = 0; c < 20; c++) begin
      drive_cycle(1'b0, '0, '0, 1'b1, acc, pop, rv, y, t, rdy);
      if (first_pop >= 0 && c == first_pop + 1) begin
        tests++;
        if (rdy !== 1'b1) begin
          fails++; $display("[TB] FAIL bp_ready_return: got %b need 1", rdy);
        end
      end
      if (pop) begin
        if (first_pop < 0) begin
          first_pop = c;
          tests++;
          if (rdy !== 1'b0) begin
            fails++; $display("[TB] FAIL bp_ready_early: got %b need 0", rdy);
          end
        end
        pops++;
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("[TB] FAIL bp_extra: unexpected y=%h tag=%0d", y, t);
        end else begin
          e = sb.pop_front();
          if (y !== e.y || t !== e.tag) begin
            fails++; $display("[TB] FAIL bp_data: got y=%h tag=%0d need y=%h tag=%0d", y, t, e.y, e.tag);
          end
        end
      end
    end
    tests++;
    if (pops != DEPTH || sb.size() != 0) begin
      fails++; $display("[TB] FAIL bp_drain: pops=%0d left=%0d need %0d and 0", pops, sb.size(), DEPTH);
    end
  endtask

  task automatic test_back_to_back();
    logic acc, pop, rv, rdy; logic [31:0] y; logic [TAG_W-1:0] t; exp_t e;
    int accepts = 0;
    for (int c = 0; c < 28; c++) begin
      if (c < 16) drive_cycle(1'b1, $urandom(), TAG_W'($urandom()), 1'b1, acc, pop, rv, y, t, rdy);
      else        drive_cycle(1'b0, '0, '0, 1'b1, acc, pop, rv, y, t, rdy);
      if (acc) accepts++;
      if (pop) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("[TB] FAIL b2b_extra: unexpected y=%h tag=%0d", y, t);
        end else begin
          e = sb.pop_front();
          if (y !== e.y || t !== e.tag) begin
            fails++; $display("[TB] FAIL b2b_data: got y=%h tag=%0d need y=%h tag=%0d", y, t, e.y, e.tag);
          end
        end
      end
    end
    tests++;
    if (accepts != 16 || sb.size() != 0) begin
      fails++; $display("[TB] FAIL b2b_throughput: accepts=%0d left=%0d need 16 and 0", accepts, sb.size());
    end
  endtask

  task automatic test_sync_err();
    logic acc, pop, rv, rdy; logic [31:0] y; logic [TAG_W-1:0] t; exp_t e;
    drop = 1'b1;
    for (int c = 0; c < 10; c++) begin
      drive_cycle(c == 0, 32'h41800000, 4'd3, 1'b1, acc, pop, rv, y, t, rdy);
      if (pop) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("[TB] FAIL sync_extra: unexpected y=%h tag=%0d", y, t);
        end else begin
          e = sb.pop_front();
          if (y !== e.y || t !== e.tag) begin
            fails++; $display("[TB] FAIL sync_data: got y=%h tag=%0d need y=%h tag=%0d", y, t, e.y, e.tag);
          end
        end
      end
    end
    drop = 1'b0;
    tests++;
    if (err_sync !== 1'b1) begin
      fails++; $display("[TB] FAIL sync_set: err_sync=%b need 1", err_sync);
    end
    for (int c = 0; c < 10; c++) begin
      drive_cycle(c == 0, 32'h40800000, 4'd4, 1'b1, acc, pop, rv, y, t, rdy);
      if (pop) void'(sb.pop_front());
    end
    tests++;
    if (err_sync !== 1'b1) begin
      fails++; $display("[TB] FAIL sync_sticky: err_sync=%b need 1", err_sync);
    end
  endtask

  task automatic test_reset_midflight();
    logic acc, pop, rv, rdy; logic [31:0] y; logic [TAG_W-1:0] t; exp_t e;
    int pops = 0;
    for (int c = 0; c < 6; c++)
      drive_cycle(c < 5, 32'h40800000 + 32'(c << 23), TAG_W'(c), 1'b0, acc, pop, rv, y, t, rdy);
    #1;
    tests++;
    if (rsp_valid !== 1'b1) begin
      fails++; $display("[TB] FAIL midflight_prefill: rsp_valid=%b need 1", rsp_valid);
    end
    rst = 1'b1;
    @(negedge sys_clk);
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || sq_valid !== 1'b0 || err_sync !== 1'b0 || req_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midflight_reset: rsp_valid=%b sq_valid=%b err_sync=%b ready=%b need 0/0/0/0",
               rsp_valid, sq_valid, err_sync, req_ready);
    end
    @(negedge sys_clk);
    rst = 1'b0; sb.delete();
    for (int c = 0; c < 16; c++) begin
      drive_cycle(c == 3, 32'h41100000, 4'd9, 1'b1, acc, pop, rv, y, t, rdy);
      if (c == 3) begin
        tests++;
        if (acc !== 1'b1) begin
          fails++; $display("[TB] FAIL midflight_accept: acc=%b need 1", acc);
        end
      end
      if (pop) begin
        pops++;
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("[TB] FAIL midflight_stale: unexpected y=%h tag=%0d", y, t);
        end else begin
          e = sb.pop_front();
          if (y !== e.y || t !== 4'd9) begin
            fails++; $display("[TB] FAIL midflight_data: got y=%h tag=%0d need y=%h tag=9", y, t, e.y);
          end
        end
      end
    end
    tests++;
    if (pops != 1 || err_sync !== 1'b0) begin
      fails++; $display("[TB] FAIL midflight_count: pops=%0d err_sync=%b need 1 and 0", pops, err_sync);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_specials();
    test_backpressure();
    test_back_to_back();
    test_sync_err();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fsqrt_issue_ctrl.md
Name: fsqrt_issue_ctrl

Overview:
Request/response wrapper that sits directly upstream and downstream of the 3-cycle pipelined fsqrt unit. It accepts tagged operands over a valid/ready handshake and drives fsqrt's stage1_valid/x. It re-associates fsqrt results with their tags, patches IEEE special cases that fsqrt does not handle (zero, denormal, inf, NaN), and buffers results in a credit-protected FIFO so a stalled consumer never loses an fsqrt output.

Parameters:
TAG_W, 4, width of the request/response tag
DEPTH, 8, result FIFO entries; must be at least FSQRT_LAT+2
FSQRT_LAT, 3, cycles from fsqrt stage1_valid sampled to out_valid high

Ports:
sys_clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  operand request valid
req_ready  out  1  block can accept a request this cycle
req_x  in  32  single-precision operand
req_tag  in  TAG_W  request tag, returned unchanged
sq_valid  out  1  to fsqrt stage1_valid
sq_x  out  32  to fsqrt x
sq_y  in  32  from fsqrt y
sq_out_valid  in  1  from fsqrt out_valid
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_y  out  32  result
rsp_tag  out  TAG_W  tag of result
err_sync  out  1  sticky flag: fsqrt output valid disagreed with the tag pipeline

Behaviour:
- Reset: sq_valid=0, sq_x=0, rsp_valid=0, err_sync=0, FIFO empty, inflight=0, tag pipeline cleared, state=DRAIN, drain counter=FSQRT_LAT. fsqrt shares this reset (inverted onto rstn).
- FSM states:
  - DRAIN: req_ready=0; sq_out_valid is ignored; the counter decrements each cycle; move to RUN when it reaches 0.
  - RUN: normal operation. No other exits; only rst re-enters DRAIN.
- Reset mid-operation: all in-flight work and FIFO contents are discarded. Stray fsqrt outputs during DRAIN are dropped and do not set err_sync.
- Accept: accept = req_valid & req_ready.
  - In RUN, req_ready = (count + inflight < DEPTH). This is combinational from registered state only; it never depends on req_valid or rsp_ready in the same cycle.
- Issue: registered. On accept in cycle k, sq_valid=1 and sq_x=req_x in cycle k+1; otherwise sq_valid=0 and sq_x holds.
- Every accepted operand is issued to fsqrt, including special cases, so order is strictly preserved.
- Special-case decode at accept (s = sign, e = exp[30:23], m = mant[22:0]); the result is carried with the tag:
  - e==0 (zero or denormal): {s,31'b0}
  - e==255, m!=0: 32'h7FC00000
  - e==255, m==0, s==0: 32'h7F800000
  - s==1 otherwise (negative normal or -inf): 32'h7FFFFFFF
  - else: no override; use sq_y.
- Tag pipeline: shift register of depth FSQRT_LAT holding {valid, tag, override_en, override_val}, entered alongside sq_valid. Its head aligns with sq_out_valid.
- Sync check: if head valid != sq_out_valid in RUN, set err_sync (sticky until rst). When the head is valid, the entry is written regardless.
- Write: when the head is valid, push {override_en ? override_val : sq_y, tag} into the FIFO and decrement inflight. Credits guarantee the FIFO is never full on a push.
- FIFO: rsp_valid = (count != 0); rsp_y/rsp_tag come combinationally from the head entry. Pop on rsp_valid & rsp_ready. Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Counters:
  - inflight +1 on accept, -1 on write; both in the same cycle leaves it unchanged.
  - count +1 on write, -1 on pop; both in the same cycle leaves it unchanged.
- Latency: accept in cycle k -> sq_valid in k+1 -> sq_out_valid in k+1+FSQRT_LAT -> rsp_valid in k+2+FSQRT_LAT (5 cycles at default).
- Throughput: 1 request/cycle sustained when rsp_ready is held high.
- rsp_valid/rsp_y/rsp_tag are stable while rsp_valid & !rsp_ready.

Test Plan:
- Release rst, hold req_valid=1 -> req_ready=0 for exactly 3 cycles (DRAIN). Inject sq_out_valid=1 during DRAIN -> nothing written, err_sync=0.
- Single request x=0x40800000 (4.0), tag=5, rsp_ready=1, bench fsqrt model -> rsp_valid exactly 5 cycles after accept, rsp_y=0x40000000 ±1 ulp, rsp_tag=5.
- Back-to-back specials 0x00000000, 0x80000000, 0x00000001, 0x7F800000, 0x7F800001, 0xFF800000, 0xC0800000 with tags 0..6 -> responses in order: 0x00000000, 0x80000000, 0x00000000, 0x7F800000, 0x7FC00000, 0x7FFFFFFF, 0x7FFFFFFF.
- rsp_ready=0, stream requests -> exactly 8 accepts, then req_ready=0. Assert rsp_ready -> all 8 drain in order with correct tags, req_ready returns the cycle after the first pop, no loss.
- Drop a bench sq_out_valid pulse for one request -> err_sync=1 and stays 1 until rst.
- Assert rst with 3 in flight and 2 in FIFO -> rsp_valid=0 next cycle; after DRAIN a new request gets a correct result with no stale entries.
